// File: rtl/stim_seq_gen.sv
// Stimulus sequencer: drives a DUT reset preamble, then streams a programmable
// data sequence (inc/dec/LFSR/hold) over a valid/ready handshake.
module stim_seq_gen #(
   parameter int                 WIDTH      = 16,
   parameter int                 COUNT_W    = 16,
   parameter int                 RST_CYCLES = 2,
   parameter logic [WIDTH-1:0]   LFSR_TAPS  = WIDTH'(16'hB400)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               abort,
   input  logic [1:0]         cfg_mode,
   input  logic [WIDTH-1:0]   cfg_seed,
   input  logic [WIDTH-1:0]   cfg_step,
   input  logic [COUNT_W-1:0] cfg_count,
   input  logic               stim_ready,
   output logic               dut_rst,
   output logic [WIDTH-1:0]   stim_data,
   output logic               stim_valid,
   output logic [COUNT_W-1:0] iter_cnt,
   output logic               busy,
   output logic               done
);

   localparam int          RW      = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
   localparam logic [RW-1:0] RC_LAST = RW'(RST_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RESET = 2'd1,
      S_RUN   = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [RW-1:0]      rcnt_q, rcnt_d;
   logic [1:0]         mode_q, mode_d;
   logic [WIDTH-1:0]   step_q, step_d;
   logic [COUNT_W-1:0] count_q, count_d;
   logic [WIDTH-1:0]   data_q, data_d;
   logic [COUNT_W-1:0] iter_q, iter_d;
   logic               done_q, done_d;

   function automatic logic [WIDTH-1:0] next_val(input logic [1:0] m,
                                                 input logic [WIDTH-1:0] d,
                                                 input logic [WIDTH-1:0] s);
      logic [WIDTH-1:0] r;
      r = d;
      case (m)
         2'd0:    r = d + s;
         2'd1:    r = d - s;
         2'd2:    r = d[0] ? ((d >> 1) ^ LFSR_TAPS) : (d >> 1);
         default: r = d;
      endcase
      return r;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         rcnt_q  <= '0;
         mode_q  <= '0;
         step_q  <= '0;
         count_q <= '0;
         data_q  <= '0;
         iter_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         rcnt_q  <= rcnt_d;
         mode_q  <= mode_d;
         step_q  <= step_d;
         count_q <= count_d;
         data_q  <= data_d;
         iter_q  <= iter_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      rcnt_d  = rcnt_q;
      mode_d  = mode_q;
      step_d  = step_q;
      count_d = count_q;
      data_d  = data_q;
      iter_d  = iter_q;
      done_d  = done_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            // start beats a simultaneous abort here; abort alone is a no-op
            if (start) begin
               mode_d  = cfg_mode;
               step_d  = cfg_step;
               count_d = cfg_count;
               data_d  = (cfg_mode == 2'd2 && cfg_seed == '0) ? WIDTH'(1) : cfg_seed;
               iter_d  = '0;
               done_d  = 1'b0;
               rcnt_d  = '0;
               state_d = S_RESET;
            end
         end
         S_RESET: begin
            if (abort) begin
               done_d  = 1'b0;
               state_d = S_IDLE;
            end else if (rcnt_q == RC_LAST) begin
               state_d = (count_q == '0) ? S_DONE : S_RUN;
               done_d  = (count_q == '0);
            end else begin
               rcnt_d = rcnt_q + 1'b1;
            end
         end
         S_RUN: begin
            // abort discards a transfer offered on the same cycle
            if (abort) begin
               done_d  = 1'b0;
               state_d = S_IDLE;
            end else if (stim_ready) begin
               iter_d = iter_q + 1'b1;
               data_d = next_val(mode_q, data_q, step_q);
               if (iter_d == count_q) begin
                  done_d  = 1'b1;
                  state_d = S_DONE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign dut_rst    = (state_q == S_RESET);
   assign stim_valid = (state_q == S_RUN);
   assign busy       = (state_q == S_RESET) || (state_q == S_RUN);
   assign stim_data  = data_q;
   assign iter_cnt   = iter_q;
   assign done       = done_q;

endmodule

// File: tb/tb_stim_seq_gen.sv
// Directed bench for stim_seq_gen: expected stim_data values are queued when a
// sequence is configured and popped as the DUT completes each transfer.
module tb_stim_seq_gen;

   logic        clk = 1'b0;
   logic        rst, start, abort, stim_ready;
   logic [1:0]  cfg_mode;
   logic [15:0] cfg_seed, cfg_step, cfg_count;
   logic        dut_rst, stim_valid, busy, done;
   logic [15:0] stim_data, iter_cnt;

   logic [15:0] sb[$];
   logic [15:0] exp_after;
   int          npass = 0;
   int          ntot  = 0;

   stim_seq_gen dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .cfg_mode(cfg_mode), .cfg_seed(cfg_seed), .cfg_step(cfg_step),
      .cfg_count(cfg_count), .stim_ready(stim_ready),
      .dut_rst(dut_rst), .stim_data(stim_data), .stim_valid(stim_valid),
      .iter_cnt(iter_cnt), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ntot++;
      assert (obs === exp) npass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic logic [15:0] model_next(input logic [1:0] m, input logic [15:0] d,
                                              input logic [15:0] s);
      case (m)
         2'd0:    return d + s;
         2'd1:    return d - s;
         2'd2:    return d[0] ? ((d >> 1) ^ 16'hB400) : (d >> 1);
         default: return d;
      endcase
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // configure inputs and queue the values the sequence must produce
   task automatic load(input logic [1:0] m, input logic [15:0] seed, input logic [15:0] step,
                       input logic [15:0] cnt);
      logic [15:0] d;
      cfg_mode = m; cfg_seed = seed; cfg_step = step; cfg_count = cnt;
      d = (m == 2'd2 && seed == 16'h0) ? 16'h0001 : seed;
      for (int i = 0; i < int'(cnt); i++) begin
         sb.push_back(d);
         d = model_next(m, d, step);
      end
      exp_after = d;
   endtask

   task automatic do_start;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic reset_checks(input string tag);
      chk({tag, " dut_rst"}, dut_rst, 0);
      chk({tag, " data"}, stim_data, 0);
      chk({tag, " valid"}, stim_valid, 0);
      chk({tag, " iter"}, iter_cnt, 0);
      chk({tag, " busy"}, busy, 0);
      chk({tag, " done"}, done, 0);
   endtask

   task automatic preamble(input string tag);
      int n = 0;
      int bad = 0;
      while (dut_rst === 1'b1 && n < 50) begin
         if (stim_valid !== 1'b0 || busy !== 1'b1) bad++;
         n++;
         tick();
      end
      chk({tag, " rst cycles"}, n, 2);
      chk({tag, " preamble outputs"}, bad, 0);
   endtask

   // drive ready (constant 1 or toggling 1,0,...) until the run leaves RUN
   task automatic stream(input bit toggle, input int start_at, input string tag);
      int cyc = 0;
      while (stim_valid === 1'b1 && cyc < 200) begin
         stim_ready = toggle ? (cyc % 2 == 0) : 1'b1;
         if (cyc == start_at) begin
            start = 1'b1; cfg_mode = 2'd3; cfg_seed = 16'h0;
         end
         if (sb.size() == 0) chk({tag, " queue underrun"}, sb.size(), 1);
         else if (stim_ready) chk({tag, " data"}, stim_data, sb.pop_front());
         else chk({tag, " hold"}, stim_data, sb[0]);
         tick();
         start = 1'b0;
         cyc++;
      end
      stim_ready = 1'b0;
      chk({tag, " ended"}, stim_valid, 0);
      chk({tag, " queue drained"}, sb.size(), 0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; abort = 1'b0; stim_ready = 1'b0;
      cfg_mode = '0; cfg_seed = '0; cfg_step = '0; cfg_count = '0;
      tick(); tick();
      rst = 1'b0;
      reset_checks("reset");

      // increment run
      load(2'd0, 16'd11869, 16'd1, 16'd10);
      do_start();
      chk("inc dut_rst", dut_rst, 1);
      preamble("inc");
      stream(1'b0, -1, "inc");
      chk("inc done", done, 1);
      chk("inc iter", iter_cnt, 10);
      chk("inc busy", busy, 0);
      chk("inc final data", stim_data, exp_after);

      // zero-length sequence started straight from DONE
      load(2'd0, 16'd5, 16'd1, 16'd0);
      do_start();
      chk("zero done cleared", done, 0);
      preamble("zero");
      chk("zero done", done, 1);
      chk("zero valid", stim_valid, 0);
      chk("zero iter", iter_cnt, 0);
      chk("zero busy", busy, 0);

      // backpressure with wraparound
      load(2'd0, 16'hFFFE, 16'd3, 16'd3);
      do_start();
      preamble("bp");
      stream(1'b1, -1, "bp");
      chk("bp done", done, 1);
      chk("bp iter", iter_cnt, 3);

      // LFSR with zero seed
      load(2'd2, 16'h0000, 16'd0, 16'd3);
      do_start();
      preamble("lfsr");
      stream(1'b0, -1, "lfsr");
      chk("lfsr iter", iter_cnt, 3);
      chk("lfsr final data", stim_data, exp_after);

      // start pulsed mid-run must be ignored
      load(2'd0, 16'd500, 16'd1, 16'd3);
      do_start();
      preamble("ign");
      stream(1'b0, 1, "ign");
      chk("ign iter", iter_cnt, 3);
      chk("ign done", done, 1);

      // abort together with the 4th transfer
      load(2'd0, 16'd100, 16'd2, 16'd10);
      do_start();
      preamble("abort");
      for (int k = 0; k < 4; k++) begin
         stim_ready = 1'b1;
         if (k == 3) abort = 1'b1;
         chk("abort valid", stim_valid, 1);
         chk("abort data", stim_data, sb.pop_front());
         tick();
      end
      abort = 1'b0; stim_ready = 1'b0;
      chk("abort busy", busy, 0);
      chk("abort valid after", stim_valid, 0);
      chk("abort dut_rst", dut_rst, 0);
      chk("abort done", done, 0);
      chk("abort iter", iter_cnt, 3);
      sb.delete();

      // rst during RESET
      load(2'd0, 16'd7, 16'd1, 16'd5);
      do_start();
      chk("rstmid in preamble", dut_rst, 1);
      rst = 1'b1; tick(); rst = 1'b0;
      reset_checks("rst in RESET");
      sb.delete();

      // rst during RUN
      load(2'd0, 16'd7, 16'd1, 16'd5);
      do_start();
      preamble("rstmid");
      stim_ready = 1'b1; tick();
      chk("rstmid one transfer", iter_cnt, 1);
      rst = 1'b1; tick(); rst = 1'b0; stim_ready = 1'b0;
      reset_checks("rst in RUN");
      sb.delete();

      // decrement after reset
      load(2'd1, 16'd10, 16'd4, 16'd3);
      do_start();
      preamble("dec");
      stream(1'b0, -1, "dec");
      chk("dec iter", iter_cnt, 3);
      chk("dec done", done, 1);
      chk("dec final data", stim_data, exp_after);

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule

// File: doc/stim_seq_gen.md
Name: stim_seq_gen

Overview:
- Synthesizable, parametrised stimulus sequencer that drives a DUT (e.g. the TOP datapath) with a reset preamble followed by a programmable data sequence.
- Generalises a fixed incrementing-vector stimulus: adds configurable width, seed, step and length, plus selectable sequence mode and a valid/ready handshake.
- Sits between a bench/host controller and the DUT input port; reports progress and completion.

Parameters:
- WIDTH, 16, stim_data width in bits.
- COUNT_W, 16, width of cfg_count and iter_cnt.
- RST_CYCLES, 2, cycles dut_rst is held high in the preamble (>=1).
- LFSR_TAPS, 16'hB400, Galois feedback mask for LFSR mode (WIDTH bits).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to begin a sequence.
- abort  in  1  terminate a running sequence.
- cfg_mode  in  2  0=increment, 1=decrement, 2=LFSR, 3=hold.
- cfg_seed  in  WIDTH  first data value.
- cfg_step  in  WIDTH  increment/decrement amount.
- cfg_count  in  COUNT_W  number of data transfers.
- stim_ready  in  1  DUT accepts the current stim_data.
- dut_rst  out  1  reset driven to the DUT.
- stim_data  out  WIDTH  current stimulus value.
- stim_valid  out  1  stim_data is valid.
- iter_cnt  out  COUNT_W  completed transfers in the current sequence.
- busy  out  1  high in RESET or RUN.
- done  out  1  sticky sequence-complete flag.

Behaviour:
- Reset values: dut_rst=0, stim_data=0, stim_valid=0, iter_cnt=0, busy=0, done=0; FSM=IDLE. rst mid-sequence returns to these values on the next edge.
- FSM states:
  - IDLE: wait for start.
  - RESET: preamble, dut_rst=1.
  - RUN: stream data.
  - DONE: sequence complete.
- Start handling:
  - start is honoured only in IDLE or DONE; it is ignored in RESET or RUN.
  - On an honoured start, cfg_* is latched, iter_cnt=0, done=0, stim_data=seed, and the FSM enters RESET.
  - In LFSR mode, a seed of 0 is replaced by 1.
- RESET: dut_rst=1, stim_valid=0, busy=1 for exactly RST_CYCLES cycles. Then go to RUN, or directly to DONE when the latched count=0.
- RUN:
  - dut_rst=0, stim_valid=1, busy=1.
  - A transfer occurs on a cycle with stim_valid & stim_ready.
  - On a transfer, iter_cnt increments and stim_data takes the next value on the following edge.
  - stim_data is stable while stim_ready=0.
- Next-value rules:
  - Mode 0: data+step, mod 2^WIDTH.
  - Mode 1: data-step, mod 2^WIDTH.
  - Mode 2: if data[0], (data>>1)^LFSR_TAPS, else data>>1.
  - Mode 3: data is unchanged.
- Transfer number count moves the FSM to DONE on the same edge. After that edge: stim_valid=0, busy=0, done=1, and iter_cnt=count. stim_data advances once more and then holds.
- DONE: done stays high until the next honoured start or rst. start in DONE restarts immediately (done clears on that edge).
- abort:
  - In RESET or RUN: go to IDLE next edge with dut_rst=0, stim_valid=0, busy=0, done=0; iter_cnt holds its value.
  - abort wins over a simultaneous transfer; that transfer is not counted.
  - In IDLE or DONE, abort is ignored.
- Simultaneous start and abort in IDLE/DONE: start wins.
- iter_cnt never wraps; cfg_count is bounded by 2^COUNT_W-1.

Test Plan:
- Increment sequence: mode=0, seed=11869, step=1, count=10, stim_ready=1 after start.
  - dut_rst high for 2 cycles.
  - stim_data 11869..11878 on consecutive valid cycles.
  - done=1 with iter_cnt=10 one cycle after the 10th transfer.
- Backpressure and wrap: mode=0, seed=16'hFFFE, step=3, count=3; stim_ready toggles 1,0,1,0,...
  - Values 16'hFFFE, 16'h0001, 16'h0004.
  - Each value is held steady while stim_ready=0.
- LFSR zero-seed substitution: mode=2, seed=0, count=3.
  - Outputs 16'h0001, 16'hB400, 16'h5A00.
- Zero-length sequence: count=0.
  - RESET lasts 2 cycles, then DONE.
  - stim_valid never asserts; iter_cnt=0; done=1.
- Abort with transfer: abort together with stim_ready during the 4th valid cycle of a count=10 run.
  - Next state is IDLE; iter_cnt=3; done=0; stim_valid=0.
  - start during RUN in a separate run is ignored.
- Reset mid-sequence: rst asserted during RESET and during RUN.
  - All outputs return to reset values next edge.
  - A subsequent start with mode=1, seed=10, step=4, count=3 yields 10, 6, 2.
